mem_arbit_rr: RTL and testbench
===============================

MEM_ARBIT_RR -- requirements
Module: mem_arbit_rr

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesters; port 0 is IF, port 1 is MEM.
REQ-002 Parameter ADDR_W, default 8, address width.
REQ-003 Parameter DATA_W, default 8, data width.
REQ-004 Parameter PRIO_RR, default 1; 1 = round-robin, 0 = fixed priority with port 0 highest.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req  in  NUM_PORTS  per-port request; held until the port's done pulse.
REQ-008 rd  in  NUM_PORTS  per-port read command.
REQ-009 wr  in  NUM_PORTS  per-port write command.
REQ-010 addr  in  NUM_PORTS*ADDR_W  flattened per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-011 wdata  in  NUM_PORTS*DATA_W  flattened per-port write data.
REQ-012 gnt  out  NUM_PORTS  one-hot grant, held for the whole transaction.
REQ-013 done  out  NUM_PORTS  one-cycle completion pulse.
REQ-014 stall  out  NUM_PORTS  req[i] & ~done[i]; combinational.
REQ-015 rdata  out  DATA_W  registered read data, valid with done.
REQ-016 mem_addr/mem_wdata  out  ADDR_W/DATA_W  memory command, driven from latched registers.
REQ-017 mem_read/mem_write  out  1 each  memory strobes.
REQ-018 mem_ready  in  1  memory completion; may stay low for any number of cycles (wait states).
REQ-019 mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1.

Function
REQ-020 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-021 A port SHALL be eligible when req[i]=1 and (rd[i]|wr[i])=1; a port with req=1 and rd=wr=0 is never granted and stalls indefinitely.
REQ-022 IDLE with ≥1 eligible port: pick the winner, latch its index, rd/wr, addr and wdata, set gnt, and move to BUSY on the same edge.
REQ-023 If rd and wr are both set, a write SHALL be performed and the read ignored.
REQ-024 BUSY: mem_read/mem_write SHALL follow the latched command; mem_addr and mem_wdata SHALL stay stable until mem_ready.
REQ-025 BUSY with mem_ready=1: pulse done[winner] for one cycle, register rdata (reads only; otherwise hold the previous value), and clear gnt.
REQ-026 On the same edge, if another eligible port exists, grant it and stay in BUSY (back-to-back, zero idle cycles); otherwise go to IDLE.
REQ-027 Minimum latency, req to done, SHALL be 2 cycles with zero wait states.
REQ-028 Round-robin: on completion, the pointer SHALL become winner+1 mod NUM_PORTS; the search starts at the pointer.
REQ-029 Fixed priority: the lowest eligible index wins; the pointer is unused.
REQ-030 Requests arriving during BUSY SHALL NOT preempt the current transaction.
REQ-031 A port dropping req while granted is a protocol violation; the transaction SHALL still complete and pulse done.

Reset
REQ-032 Reset SHALL force: state=IDLE, gnt=0, done=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, rdata=0, pointer=0.
REQ-033 Reset asserted in BUSY SHALL abort the transaction; strobes are low on the cycle after the reset edge and no done pulse is issued.

Configuration
REQ-034 Macro MEM_ARBIT_LOCK_EN, when defined, SHALL add input lock[NUM_PORTS].
REQ-035 With MEM_ARBIT_LOCK_EN: if lock[winner]=1 at completion and that port is eligible, the same port SHALL be re-granted immediately, overriding priority, and the pointer SHALL NOT advance.
REQ-036 Without MEM_ARBIT_LOCK_EN: the lock port SHALL be absent and arbitration is pure per REQ-028/029.

Structure
REQ-037 Package mem_arbit_pkg SHALL hold the state enum {IDLE, BUSY} and the PRIO_FIXED/PRIO_RR mode constants.
REQ-038 The winner search SHALL be the sub-module arb_rr_pick: inputs eligible vector and pointer; outputs one-hot winner and valid.

Verification
REQ-039 The bench SHALL cover the following directed scenarios.
REQ-040 Single read: req[0]=1, rd, addr=0x10, mem_ready=1 with mem_rdata=0xA5 -> done[0] 2 cycles after req, rdata=0xA5, stall[0] high for 2 cycles.
REQ-041 Simultaneous requests with PRIO_RR=1: both ports request continuously -> grants alternate 0,1,0,1 with no IDLE cycles; with PRIO_RR=0 -> port 0 always wins.
REQ-042 Wait states: a write with mem_ready low for 3 cycles -> mem_write, mem_addr and mem_wdata stable for 4 cycles, then done exactly once.
REQ-043 Reset mid-op: reset asserted in BUSY -> next cycle all strobes=0, gnt=0, no done; a request issued after reset is served normally.
REQ-044 Lock (MEM_ARBIT_LOCK_EN): port 1 locked, port 0 requesting -> port 1 re-granted; after lock drops -> port 0 granted next.
REQ-045 Invalid command: req with rd=wr=0 -> never granted; other ports are unaffected.

Source files
------------

// File: rtl/mem_arbit_pkg.sv
// Shared types and mode constants for the memory arbiter.
package mem_arbit_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;
endpackage

// File: rtl/mem_arbit_rr_pick.sv
// Winner search: first eligible port scanning upward from the pointer, with wrap.
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_win,
    output logic          o_valid
);
    import mem_arbit_pkg::*;

    logic [PW-1:0] w_idx;

    always_comb begin
        o_win   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!o_valid && i_elig[w_idx]) begin
                o_win[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbit_rr.sv
// Multi-port memory arbiter, round-robin or fixed priority, one transaction at a time.
// Define MEM_ARBIT_LOCK_EN to add the per-port lock input (locked winner is re-granted).
module mem_arbit_rr #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int PRIO_RR   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        rd,
    input  logic [NUM_PORTS-1:0]        wr,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
`ifdef MEM_ARBIT_LOCK_EN
    input  logic [NUM_PORTS-1:0]        lock,
`endif
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        done,
    output logic [NUM_PORTS-1:0]        stall,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_read,
    output logic                        mem_write,
    input  logic                        mem_ready,
    input  logic [DATA_W-1:0]           mem_rdata
);
    import mem_arbit_pkg::*;

    localparam int PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam bit RR_MODE = (PRIO_RR == mem_arbit_pkg::PRIO_RR);

    state_e                r_state;
    logic [NUM_PORTS-1:0]  r_gnt, r_done;
    logic [PW-1:0]         r_win, r_ptr;
    logic                  r_mem_read, r_mem_write;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata, r_rdata;

    logic [NUM_PORTS-1:0]  w_elig, w_pick, w_sel_oh;
    logic [PW-1:0]         w_pick_idx, w_sel_idx, w_ptr_nxt, w_ptr_use;
    logic                  w_pick_vld, w_sel_vld, w_complete, w_launch, w_relock;

    assign w_elig     = req & (rd | wr);
    assign w_complete = (r_state == BUSY) && mem_ready;
    assign w_ptr_nxt  = (r_win == PW'(NUM_PORTS - 1)) ? '0 : r_win + PW'(1);
    // At a completion edge the search must already start past the finishing winner.
    assign w_ptr_use  = !RR_MODE ? '0 : (r_state == BUSY) ? w_ptr_nxt : r_ptr;

`ifdef MEM_ARBIT_LOCK_EN
    assign w_relock = (r_state == BUSY) && lock[r_win] && w_elig[r_win];
`else
    assign w_relock = 1'b0;
`endif

    arb_rr_pick #(.N(NUM_PORTS), .PW(PW)) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (w_ptr_use),
        .o_win   (w_pick),
        .o_valid (w_pick_vld)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (w_pick[i]) w_pick_idx = PW'(i);
    end

    assign w_sel_oh  = w_relock ? r_gnt : w_pick;
    assign w_sel_idx = w_relock ? r_win : w_pick_idx;
    assign w_sel_vld = w_relock | w_pick_vld;
    assign w_launch  = ((r_state == IDLE) || w_complete) && w_sel_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_done      <= '0;
            r_win       <= '0;
            r_ptr       <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_done <= w_complete ? r_gnt : '0;
            if (w_complete && r_mem_read)
                r_rdata <= mem_rdata;
            if (w_complete && RR_MODE && !w_relock)
                r_ptr <= w_ptr_nxt;
            if (w_launch) begin
                r_state     <= BUSY;
                r_gnt       <= w_sel_oh;
                r_win       <= w_sel_idx;
                r_mem_write <= wr[w_sel_idx];
                r_mem_read  <= rd[w_sel_idx] & ~wr[w_sel_idx];
                r_mem_addr  <= addr[w_sel_idx*ADDR_W +: ADDR_W];
                r_mem_wdata <= wdata[w_sel_idx*DATA_W +: DATA_W];
            end else if (w_complete) begin
                r_state     <= IDLE;
                r_gnt       <= '0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign stall     = req & ~r_done;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
endmodule

// File: tb/tb_mem_arbit_rr.sv
// Directed bench for mem_arbit_rr: RR instance scoreboarded, fixed-priority twin for contention.
module tb_mem_arbit_rr;
    localparam int NP = 2;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    logic [NP-1:0]    req, rd, wr, lock;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] wdata;
    logic             mem_ready;
    logic [7:0]       key;

    logic [NP-1:0] gnt, done, stall, gnt_f, done_f, stall_f;
    logic [DW-1:0] rdata, rdata_f, mem_wdata, mem_wdata_f, mem_rdata, mem_rdata_f;
    logic [AW-1:0] mem_addr, mem_addr_f;
    logic          mem_read, mem_write, mem_read_f, mem_write_f;

    always #5 clk = ~clk;

    assign mem_rdata   = mem_addr ^ key;
    assign mem_rdata_f = mem_addr_f ^ key;

    mem_arbit_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_RR(1)) dut (
        .clk(clk), .reset(reset), .req(req), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
`ifdef MEM_ARBIT_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .done(done), .stall(stall), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_arbit_rr #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_RR(0)) dut_fix (
        .clk(clk), .reset(reset), .req(req), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
`ifdef MEM_ARBIT_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt_f), .done(done_f), .stall(stall_f), .rdata(rdata_f),
        .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_read(mem_read_f),
        .mem_write(mem_write_f), .mem_ready(mem_ready), .mem_rdata(mem_rdata_f)
    );

    typedef struct {
        int         port;
        bit         is_rd;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input bit r, input logic [7:0] d);
        exp_t e;
        e.port = p; e.is_rd = r; e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive(input int p, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        req[p] = 1'b1; rd[p] = r; wr[p] = w;
        addr[p*AW +: AW]  = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic drop(input int p);
        req[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Every done pulse retires the oldest expected transaction.
    always @(negedge clk) begin
        if (!reset && done !== '0) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_done_port", done, 32'(1) << mon_e.port);
                if (mon_e.is_rd) chk("sb_rdata", rdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = '0; rd = '0; wr = '0; lock = '0;
        addr = '0; wdata = '0; mem_ready = 1'b1; key = 8'h00;
        nxt(); nxt(); smp();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        nxt(); reset = 1'b0;

        // single zero-wait read
        nxt(); key = 8'hB5; drive(0, 1, 0, 8'h10, 8'h00); push(0, 1, 8'hA5);
        smp(); chk("rd_stall_c0", stall[0], 1); chk("rd_gnt_c0", gnt, 0);
        nxt(); smp();
        chk("rd_gnt_c1", gnt, 2'b01); chk("rd_strobe_c1", mem_read, 1);
        chk("rd_addr_c1", mem_addr, 8'h10); chk("rd_stall_c1", stall[0], 1); chk("rd_nodone_c1", done, 0);
        #1 drop(0);
        nxt(); smp();
        chk("rd_done_c2", done, 2'b01); chk("rd_rdata_c2", rdata, 8'hA5); chk("rd_stall_c2", stall[0], 0);
        nxt(); smp(); chk("rd_done_once", done, 0);

        // continuous contention: pointer now 1, so RR starts at port 1; fixed twin keeps port 0
        nxt(); key = 8'h00;
        drive(0, 1, 0, 8'h20, 8'h00); drive(1, 0, 1, 8'h31, 8'h77);
        push(1, 0, 8'h00); push(0, 1, 8'h20); push(1, 0, 8'h00); push(0, 1, 8'h20);
        for (int k = 1; k <= 4; k++) begin
            nxt(); smp();
            chk("rr_gnt_alt", gnt, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk("fix_gnt_p0", gnt_f, 2'b01);
            if (k == 4) begin #1 drop(0); drop(1); end
        end
        nxt(); smp(); chk("rr_done_last", done, 2'b01); chk("rr_idle_after", gnt, 0);

        // write with three wait states
        nxt(); mem_ready = 1'b0; drive(0, 0, 1, 8'h42, 8'h99); push(0, 0, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            nxt(); if (k == 4) mem_ready = 1'b1;
            smp();
            chk("ws_write", mem_write, 1); chk("ws_addr", mem_addr, 8'h42);
            chk("ws_wdata", mem_wdata, 8'h99); chk("ws_nodone", done, 0);
            if (k == 4) begin #1 drop(0); end
        end
        nxt(); smp();
        chk("ws_done", done, 2'b01); chk("ws_strobe_off", mem_write, 0); chk("ws_rdata_hold", rdata, 8'h20);
        nxt(); smp(); chk("ws_done_once", done, 0);

        // reset while busy aborts; the same request is served after reset
        nxt(); mem_ready = 1'b0; drive(1, 1, 0, 8'h55, 8'h00);
        nxt(); smp(); chk("ro_gnt", gnt, 2'b10); chk("ro_read", mem_read, 1);
        #1 reset = 1'b1;
        nxt(); smp();
        chk("ro_gnt_clr", gnt, 0); chk("ro_read_clr", mem_read, 0); chk("ro_write_clr", mem_write, 0);
        chk("ro_nodone", done, 0); chk("ro_addr_clr", mem_addr, 0); chk("ro_rdata_clr", rdata, 0);
        nxt(); reset = 1'b0; mem_ready = 1'b1; push(1, 1, 8'h55);
        nxt(); smp(); chk("ro_regnt", gnt, 2'b10);
        #1 drop(1);
        nxt(); smp(); chk("ro_done", done, 2'b10); chk("ro_rdata", rdata, 8'h55);

        // invalid command on port 0 is never granted; port 1 proceeds
        nxt(); req[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b0;
        drive(1, 0, 1, 8'h66, 8'h12); push(1, 0, 8'h00);
        nxt(); smp(); chk("inv_gnt_p1", gnt, 2'b10); chk("inv_stall_p0", stall[0], 1);
        #1 drop(1);
        nxt(); smp(); chk("inv_done_p1", done, 2'b10);
        for (int k = 0; k < 3; k++) begin
            chk("inv_no_gnt", gnt, 0); chk("inv_stall_hold", stall[0], 1);
            nxt(); smp();
        end
        nxt(); drop(0);

`ifdef MEM_ARBIT_LOCK_EN
        // locked port 1 is re-granted ahead of port 0, then port 0 follows
        nxt(); lock[1] = 1'b1; drive(1, 0, 1, 8'h77, 8'h3C); push(1, 0, 8'h00);
        nxt(); smp(); chk("lk_gnt_p1", gnt, 2'b10);
        #1 drive(0, 1, 0, 8'h88, 8'h00); push(1, 0, 8'h00); push(0, 1, 8'h88);
        nxt(); smp(); chk("lk_regrant", gnt, 2'b10); chk("lk_done1", done, 2'b10);
        #1 lock[1] = 1'b0; drop(1);
        nxt(); smp(); chk("lk_gnt_p0", gnt, 2'b01); chk("lk_done2", done, 2'b10);
        #1 drop(0);
        nxt(); smp(); chk("lk_done_p0", done, 2'b01);
`endif

        nxt(); nxt(); smp();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
